// File: rtl/mag_cook_sequencer_pkg.sv
// Shared types and constants for the magnetron cook sequencer.
// State encoding is also what state_o reports to the display/debug logic.
package mag_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COOKING = 3'd1,
      PAUSED  = 3'd2,
      DONE    = 3'd3
   } state_t;

   localparam logic [15:0] BCD_ZERO     = 16'h0000;
   localparam logic [15:0] BCD_ONE_SEC  = 16'h0001;
   localparam logic [3:0]  MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/mag_cook_sequencer_if.sv
// Keypad/button/door inputs and magnetron/display outputs of the cook sequencer.
// The master side is the keypad/panel; the slave side is the sequencer.
interface mag_cook_sequencer_if;
   logic        startn;
   logic        stopn;
   logic        clearn;
   logic        door_closed;
   logic        key_valid;
   logic [3:0]  key_digit;
   logic        mag_on;
   logic        timer_done;
   logic [15:0] time_bcd;
   logic [2:0]  state_o;

   modport master (
      output startn, stopn, clearn, door_closed, key_valid, key_digit,
      input  mag_on, timer_done, time_bcd, state_o
   );

   modport slave (
      input  startn, stopn, clearn, door_closed, key_valid, key_digit,
      output mag_on, timer_done, time_bcd, state_o
   );
endinterface

// File: rtl/mag_cook_sequencer_bcd_mmss_down.sv
// BCD mm:ss time register: keypad shift-in with validity check and
// one-second decrement with the seconds-tens digit wrapping at 5.
module bcd_mmss_down
   import mag_seq_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        clr,
   input  logic        shift_en,
   input  logic [3:0]  digit,
   input  logic        dec_en,
   output logic [15:0] q,
   output logic        is_zero
);

   logic [15:0] r_q;
   logic [15:0] w_dec;
   logic [3:0]  w_borrow;
   logic        w_accept;

   // Current s0 becomes s1 after the shift, so it must be a legal tens digit.
   assign w_accept = shift_en && (digit <= 4'd9) && (r_q[3:0] <= MAX_SEC_TENS);

   assign w_borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         localparam logic [3:0] WRAP = (gi == 1) ? MAX_SEC_TENS : 4'd9;
         logic [3:0] w_d;
         assign w_d = r_q[4*gi +: 4];
         assign w_dec[4*gi +: 4] = !w_borrow[gi] ? w_d :
                                   (w_d == 4'd0) ? WRAP : (w_d - 4'd1);
         if (gi < 3) begin : g_borrow
            assign w_borrow[gi+1] = w_borrow[gi] && (w_d == 4'd0);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_q <= BCD_ZERO;
      end else if (clr) begin
         r_q <= BCD_ZERO;
      end else if (w_accept) begin
         r_q <= {r_q[11:0], digit};
      end else if (dec_en) begin
         r_q <= w_dec;
      end
   end

   assign q       = r_q;
   assign is_zero = (r_q == BCD_ZERO);

endmodule

// File: rtl/mag_cook_sequencer.sv
// Magnetron cook sequencer: button edge detection, one-second prescaler and
// the IDLE/COOKING/PAUSED/DONE controller driving mag_on and timer_done.
module mag_cook_sequencer
   import mag_seq_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100,
   parameter int PRESC_W       = 7
) (
   input logic                  clk,
   input logic                  resetn,
   mag_cook_sequencer_if.slave  bus
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

   state_t               r_state, w_state_next;
   logic [PRESC_W-1:0]   r_presc, w_presc_next;
   logic                 r_start_prev, r_stop_prev, r_clear_prev, r_door_prev;
   logic                 r_timer_done;
   logic                 w_start_ev, w_stop_ev, w_clear_ev, w_door_fall;
   logic                 w_clr, w_shift_en, w_dec_en, w_is_zero;
   logic [15:0]          w_time;

   assign w_start_ev  = !bus.startn && r_start_prev;
   assign w_stop_ev   = !bus.stopn  && r_stop_prev;
   assign w_clear_ev  = !bus.clearn && r_clear_prev;
   assign w_door_fall = r_door_prev && !bus.door_closed;

   bcd_mmss_down u_time (
      .clk      (clk),
      .resetn   (resetn),
      .clr      (w_clr),
      .shift_en (w_shift_en),
      .digit    (bus.key_digit),
      .dec_en   (w_dec_en),
      .q        (w_time),
      .is_zero  (w_is_zero)
   );

   always_comb begin
      w_state_next = r_state;
      w_presc_next = r_presc;
      w_clr        = 1'b0;
      w_shift_en   = 1'b0;
      w_dec_en     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_clear_ev) begin
               w_clr        = 1'b1;
               w_presc_next = '0;
            end else begin
               // Start judges the time as it was before any key landing this cycle.
               w_shift_en = bus.key_valid;
               if (w_start_ev && bus.door_closed && !w_is_zero) begin
                  w_state_next = COOKING;
                  w_presc_next = '0;
               end
            end
         end
         COOKING: begin
            if (w_clear_ev) begin
               w_state_next = IDLE;
               w_clr        = 1'b1;
               w_presc_next = '0;
            end else if (!bus.door_closed || w_stop_ev) begin
               w_state_next = PAUSED;
            end else if (r_presc == PRESC_LAST) begin
               w_presc_next = '0;
               w_dec_en     = 1'b1;
               if (w_time == BCD_ONE_SEC) begin
                  w_state_next = DONE;
               end
            end else begin
               w_presc_next = r_presc + 1'b1;
            end
         end
         PAUSED: begin
            if (w_clear_ev || w_stop_ev) begin
               w_state_next = IDLE;
               w_clr        = 1'b1;
               w_presc_next = '0;
            end else if (w_start_ev && bus.door_closed) begin
               w_state_next = COOKING;
            end
         end
         DONE: begin
            if (w_clear_ev || w_stop_ev || w_door_fall) begin
               w_state_next = IDLE;
               w_clr        = 1'b1;
               w_presc_next = '0;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_clr        = 1'b1;
            w_presc_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_presc      <= '0;
         r_start_prev <= 1'b1;
         r_stop_prev  <= 1'b1;
         r_clear_prev <= 1'b1;
         r_door_prev  <= 1'b0;
         r_timer_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_presc      <= w_presc_next;
         r_start_prev <= bus.startn;
         r_stop_prev  <= bus.stopn;
         r_clear_prev <= bus.clearn;
         r_door_prev  <= bus.door_closed;
         r_timer_done <= (w_state_next == DONE);
      end
   end

   // Door gating is combinational so an opening door kills the magnetron immediately.
   assign bus.mag_on     = (r_state == COOKING) && bus.door_closed;
   assign bus.timer_done = r_timer_done;
   assign bus.time_bcd   = w_time;
   assign bus.state_o    = r_state;

endmodule

// File: tb/tb_mag_cook_sequencer.sv
// Self-checking bench: directed scenarios plus random panel activity, every
// cycle compared against a seconds-count behavioural model of the sequencer.
module tb_mag_cook_sequencer;

   localparam int T = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_err = 0;
   int   n_chk = 0;

   mag_cook_sequencer_if bus();

   mag_cook_sequencer #(.TICKS_PER_SEC(T), .PRESC_W(3)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Model: state 0 idle, 1 cooking, 2 paused, 3 done; time as four digits.
   int m_state = 0;
   int m_d[4];
   int m_presc = 0;
   bit m_ps = 1, m_pp = 1, m_pc = 1, m_pd = 0;

   function automatic int m_secs();
      return (m_d[3] * 10 + m_d[2]) * 60 + m_d[1] * 10 + m_d[0];
   endfunction

   task automatic m_set_secs(input int v);
      m_d[3] = v / 600;
      m_d[2] = (v / 60) % 10;
      m_d[1] = (v % 60) / 10;
      m_d[0] = v % 10;
   endtask

   function automatic logic [15:0] m_bcd();
      return {4'(m_d[3]), 4'(m_d[2]), 4'(m_d[1]), 4'(m_d[0])};
   endfunction

   task automatic m_clear();
      m_state = 0;
      m_set_secs(0);
      m_presc = 0;
   endtask

   task automatic model_step();
      bit es, ep, ec, dfall;
      int pre;
      if (!resetn) begin
         m_clear();
         m_ps = 1; m_pp = 1; m_pc = 1; m_pd = 0;
         return;
      end
      es    = !bus.startn && m_ps;
      ep    = !bus.stopn && m_pp;
      ec    = !bus.clearn && m_pc;
      dfall = m_pd && !bus.door_closed;
      m_ps = bus.startn; m_pp = bus.stopn; m_pc = bus.clearn; m_pd = bus.door_closed;
      case (m_state)
         0: if (ec) m_clear();
            else begin
               pre = m_secs();
               if (bus.key_valid && bus.key_digit <= 9 && m_d[0] <= 5) begin
                  m_d[3] = m_d[2]; m_d[2] = m_d[1]; m_d[1] = m_d[0];
                  m_d[0] = int'(bus.key_digit);
               end
               if (es && bus.door_closed && pre != 0) begin
                  m_state = 1;
                  m_presc = 0;
               end
            end
         1: if (ec) m_clear();
            else if (!bus.door_closed || ep) m_state = 2;
            else if (m_presc == T - 1) begin
               m_presc = 0;
               m_set_secs(m_secs() - 1);
               if (m_secs() == 0) m_state = 3;
            end else m_presc++;
         2: if (ec || ep) m_clear();
            else if (es && bus.door_closed) m_state = 1;
         default: if (ec || ep || dfall) m_clear();
      endcase
   endtask

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare outputs for the current inputs, then advance one clock.
   task automatic step();
      #1;
      check_val("time_bcd",   bus.time_bcd, m_bcd());
      check_val("state_o",    16'(bus.state_o), 16'(m_state));
      check_val("mag_on",     16'(bus.mag_on), 16'(m_state == 1 && bus.door_closed));
      check_val("timer_done", 16'(bus.timer_done), 16'(m_state == 3));
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic key(input logic [3:0] d);
      bus.key_valid = 1'b1;
      bus.key_digit = d;
      step();
      bus.key_valid = 1'b0;
   endtask

   task automatic press_start();
      bus.startn = 1'b0; step(); bus.startn = 1'b1; step();
   endtask

   task automatic press_stop();
      bus.stopn = 1'b0; step(); bus.stopn = 1'b1; step();
   endtask

   task automatic press_clear();
      bus.clearn = 1'b0; step(); bus.clearn = 1'b1; step();
   endtask

   initial begin
      bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
      bus.door_closed = 1'b1; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
      m_set_secs(0);
      @(posedge clk);
      model_step();
      #1;
      resetn = 1'b1;
      cyc(2);

      // 01:30 countdown
      key(4'd0); key(4'd1); key(4'd3); key(4'd0);
      press_start();
      cyc(125);
      press_clear();

      // 00:02 to DONE, held start must not restart
      key(4'd0); key(4'd2);
      press_start();
      cyc(8);
      bus.startn = 1'b0; cyc(6); bus.startn = 1'b1; cyc(2);
      press_clear();

      // door open pause and resume
      key(4'd1); key(4'd0);
      press_start();
      cyc(3);
      bus.door_closed = 1'b0; cyc(3);
      bus.door_closed = 1'b1; cyc(1);
      press_start();
      cyc(10);
      press_clear();

      // key entry rules
      key(4'd1); key(4'd7); key(4'd9); key(4'd12); cyc(1);
      press_clear();

      // start refused with zero time or door open, clear mid-cook
      press_start();
      bus.door_closed = 1'b0; key(4'd5); press_start();
      bus.door_closed = 1'b1; press_start();
      cyc(6);
      press_clear();

      // reset mid-cook, then simultaneous stop+start, then second stop
      key(4'd4); key(4'd5); press_start(); cyc(5);
      resetn = 1'b0; step(); resetn = 1'b1; cyc(1);
      key(4'd3); press_start(); cyc(3);
      bus.stopn = 1'b0; bus.startn = 1'b0; step();
      bus.stopn = 1'b1; bus.startn = 1'b1; cyc(2);
      press_stop(); cyc(1);

      // DONE exited by door opening
      key(4'd1); press_start(); cyc(6);
      bus.door_closed = 1'b0; cyc(2); bus.door_closed = 1'b1; cyc(1);

      // random panel activity
      for (int i = 0; i < 5000; i++) begin
         if (!bus.startn) bus.startn = ($urandom_range(0, 1) == 0);
         else             bus.startn = ($urandom_range(0, 15) != 0);
         if (!bus.stopn)  bus.stopn  = ($urandom_range(0, 1) == 0);
         else             bus.stopn  = ($urandom_range(0, 79) != 0);
         if (!bus.clearn) bus.clearn = 1'b1;
         else             bus.clearn = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 59) == 0) bus.door_closed = ~bus.door_closed;
         bus.key_valid = ($urandom_range(0, 4) == 0);
         bus.key_digit = 4'($urandom_range(0, 15));
         resetn = ($urandom_range(0, 999) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
